// File: rtl/rose_stim_gen.sv
// Stimulus generator for an `a |-> $rose(b)` checker: plays FIFO-loaded vectors and emits the expected verdicts.
// Define ROSE_STIM_GEN_FELL_EN to model `a |-> $fell(b)` instead.
module rose_stim_gen #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic             wr_a,
  input  logic             wr_b,
  output logic             wr_rdy,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             exp_vld,
  output logic             exp_pass,
  output logic             exp_vac,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef ROSE_STIM_GEN_FELL_EN
  localparam logic PREV_INIT = 1'b1;
`else
  localparam logic PREV_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic [1:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              prev_b_q;
  logic              a_q, b_q, vld_q, pass_q, vac_q, busy_q, done_q;
  logic [CNT_W-1:0]  pass_cnt_q, fail_cnt_q, vac_cnt_q;

  logic wr_fire, start_ok, va, vb, pass_d, vac_d;

  assign wr_rdy   = (state_q == IDLE) && (count_q != FULL_CNT);
  assign wr_fire  = wr_vld && wr_rdy;
  assign start_ok = (state_q == IDLE) && start && ((count_q != '0) || wr_fire);

  assign {va, vb} = mem_q[rd_ptr_q];
  assign vac_d    = !va;
`ifdef ROSE_STIM_GEN_FELL_EN
  assign pass_d   = !va || (!vb && prev_b_q);
`else
  assign pass_d   = !va || (vb && !prev_b_q);
`endif

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= {wr_a, wr_b};
  end

  // busy is held through the done cycle and drops one cycle after returning to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_b_q   <= PREV_INIT;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      vld_q      <= 1'b0;
      pass_q     <= 1'b0;
      vac_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      vac_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= start_ok;
          if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_q + (AW+1)'(1);
          end
          if (start_ok) begin
            state_q    <= RUN;
            prev_b_q   <= PREV_INIT;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            vac_cnt_q  <= '0;
          end
        end
        RUN: begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          count_q  <= count_q - (AW+1)'(1);
          a_q      <= va;
          b_q      <= vb;
          vld_q    <= 1'b1;
          pass_q   <= pass_d;
          vac_q    <= vac_d;
          prev_b_q <= vb;
          if (vac_d) begin
            if (!(&vac_cnt_q)) vac_cnt_q <= vac_cnt_q + CNT_W'(1);
          end else if (pass_d) begin
            if (!(&pass_cnt_q)) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
          end else begin
            if (!(&fail_cnt_q)) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
          end
          if (count_q == (AW+1)'(1)) state_q <= DONE;
        end
        DONE: begin
          a_q     <= 1'b0;
          b_q     <= 1'b0;
          vld_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign exp_vld  = vld_q;
  assign exp_pass = pass_q;
  assign exp_vac  = vac_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign vac_cnt  = vac_cnt_q;

endmodule

// File: tb/tb_rose_stim_gen.sv
// Scoreboard bench for rose_stim_gen: vectors and their expected verdicts are queued on write and
// popped as the generator plays them back.
module tb_rose_stim_gen;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

`ifdef ROSE_STIM_GEN_FELL_EN
  localparam logic PREV_INIT = 1'b1;
`else
  localparam logic PREV_INIT = 1'b0;
`endif

  typedef struct packed {logic a; logic b; logic pass; logic vac;} vec_t;

  logic clk, rst, wr_vld, wr_a, wr_b, wr_rdy, start;
  logic a_o, b_o, exp_vld, exp_pass, exp_vac, busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, vac_cnt;

  vec_t sbQ[$];
  logic modelPrevB;
  int   expPass, expFail, expVac;
  int   checks, errors;

  rose_stim_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_a(wr_a), .wr_b(wr_b), .wr_rdy(wr_rdy),
    .start(start), .a_o(a_o), .b_o(b_o), .exp_vld(exp_vld), .exp_pass(exp_pass),
    .exp_vac(exp_vac), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .vac_cnt(vac_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The first vector of a run sees the run-start history value
  function automatic void pushModel(input logic a, input logic b);
    vec_t v;
    if (sbQ.size() == 0) modelPrevB = PREV_INIT;
    v.a   = a;
    v.b   = b;
    v.vac = !a;
`ifdef ROSE_STIM_GEN_FELL_EN
    v.pass = !a || (!b && modelPrevB);
`else
    v.pass = !a || (b && !modelPrevB);
`endif
    modelPrevB = b;
    sbQ.push_back(v);
  endfunction

  task automatic applyStimulus(input logic a, input logic b);
    logic accept;
    @(negedge clk);
    accept = (sbQ.size() < DEPTH);
    checkOutput("wr_rdy_idle", wr_rdy, accept);
    wr_vld = 1'b1;
    wr_a   = a;
    wr_b   = b;
    if (accept) pushModel(a, b);
  endtask

  task automatic startRun(input logic withWr, input logic a, input logic b);
    logic accept;
    @(negedge clk);
    checkOutput("busy_before_start", busy, 0);
    start  = 1'b1;
    wr_vld = withWr;
    wr_a   = a;
    wr_b   = b;
    if (withWr) begin
      accept = (sbQ.size() < DEPTH);
      checkOutput("wr_rdy_at_start", wr_rdy, accept);
      if (accept) pushModel(a, b);
    end
    @(negedge clk);
    start  = 1'b0;
    wr_vld = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("exp_vld_before_vec0", exp_vld, 0);
    checkOutput("wr_rdy_in_run", wr_rdy, 0);
    expPass = 0;
    expFail = 0;
    expVac  = 0;
  endtask

  task automatic playback(input int limit);
    vec_t v;
    int n;
    n = (limit < sbQ.size()) ? limit : sbQ.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v = sbQ.pop_front();
      if (v.vac) expVac++;
      else if (v.pass) expPass++;
      else expFail++;
      checkOutput("a_o", a_o, v.a);
      checkOutput("b_o", b_o, v.b);
      checkOutput("exp_vld", exp_vld, 1);
      checkOutput("exp_pass", exp_pass, v.pass);
      checkOutput("exp_vac", exp_vac, v.vac);
      checkOutput("wr_rdy_run", wr_rdy, 0);
      checkOutput("done_early", done, 0);
      checkOutput("pass_cnt", pass_cnt, expPass);
      checkOutput("fail_cnt", fail_cnt, expFail);
      checkOutput("vac_cnt", vac_cnt, expVac);
    end
    if (sbQ.size() == 0) begin
      @(negedge clk);
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_in_done", busy, 1);
      checkOutput("exp_vld_in_done", exp_vld, 0);
      checkOutput("a_o_in_done", a_o, 0);
      checkOutput("b_o_in_done", b_o, 0);
      @(negedge clk);
      checkOutput("done_clear", done, 0);
      checkOutput("busy_clear", busy, 0);
      checkOutput("wr_rdy_after", wr_rdy, 1);
      checkOutput("pass_cnt_hold", pass_cnt, expPass);
      checkOutput("fail_cnt_hold", fail_cnt, expFail);
      checkOutput("vac_cnt_hold", vac_cnt, expVac);
    end
  endtask

  task automatic emptyStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty_start_busy", busy, 0);
      checkOutput("empty_start_done", done, 0);
      checkOutput("empty_start_vld", exp_vld, 0);
      checkOutput("empty_start_rdy", wr_rdy, 1);
      @(negedge clk);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_wr_rdy"}, wr_rdy, 1);
    checkOutput({tag, "_a_o"}, a_o, 0);
    checkOutput({tag, "_b_o"}, b_o, 0);
    checkOutput({tag, "_exp_vld"}, exp_vld, 0);
    checkOutput({tag, "_exp_pass"}, exp_pass, 0);
    checkOutput({tag, "_exp_vac"}, exp_vac, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass_cnt"}, pass_cnt, 0);
    checkOutput({tag, "_fail_cnt"}, fail_cnt, 0);
    checkOutput({tag, "_vac_cnt"}, vac_cnt, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelPrevB = PREV_INIT;
    rst = 1'b1; start = 1'b0; wr_vld = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;

    $display("[TB] mixed five-vector run");
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    startRun(0, 0, 0);
    playback(DEPTH);
`ifndef ROSE_STIM_GEN_FELL_EN
    checkOutput("t1_pass_total", pass_cnt, 2);
    checkOutput("t1_fail_total", fail_cnt, 1);
    checkOutput("t1_vac_total", vac_cnt, 2);
`endif

    $display("[TB] repeated high b");
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    startRun(0, 0, 0);
    playback(DEPTH);
`ifndef ROSE_STIM_GEN_FELL_EN
    checkOutput("t2_pass_total", pass_cnt, 1);
    checkOutput("t2_fail_total", fail_cnt, 1);
    checkOutput("t2_vac_total", vac_cnt, 0);
`endif

    $display("[TB] overfill");
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(i[0] ^ i[2], i[1]);
    end
    startRun(0, 0, 0);
    playback(DEPTH + 4);

    $display("[TB] empty start then start with write");
    emptyStart();
    startRun(1, 1, 1);
    playback(DEPTH);

    $display("[TB] reset mid-run");
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    startRun(0, 0, 0);
    playback(2);
    rst = 1'b1;
    #1;
    checkIdleZero("midrun_reset");
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    emptyStart();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
